router_dst_reader: RTL and testbench

- Destination-side drain engine for one router output port.
- Reads packet bytes out of the port FIFO using its not-empty and read-enable interface.
- Reassembles each packet (header, payload, parity), checks the header address and parity, and presents a byte stream plus a per-packet summary to the downstream consumer.
- Sits between a router output FIFO and the destination logic or testbench sink.

---
 rtl/router_dst_reader.sv | 147 ++++++++++++++
 tb/tb_router_dst_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/router_dst_reader.sv
// Destination-side drain engine: reads one router output FIFO, reassembles packets
// and reports per-packet summaries. Define ROUTER_DST_PARITY_CHK_EN to enable the parity check.
module router_dst_reader #(
    parameter logic [1:0] PORT_ID = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_out,
    input  logic [7:0] d_out,
    input  logic       sreset,
    input  logic       hold,
    output logic       read_enb,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_sof,
    output logic       byte_eof,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic [1:0] pkt_addr,
    output logic       parity_err,
    output logic       addr_err,
    output logic [7:0] pkt_cnt
);

    typedef enum logic [1:0] {IDLE, HDR_WAIT, BODY, DONE} state_t;

    state_t     state, state_nxt;
    logic       rd_q;
    logic [6:0] issue_rem;
    logic [6:0] recv_rem;
    logic       issue_ok;
    logic       last_cap;

    assign last_cap = (state == BODY) && rd_q && (recv_rem == 7'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        issue_ok  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE:     issue_ok = 1'b1;
            HDR_WAIT: issue_ok = 1'b0;
            BODY:     issue_ok = (issue_rem != 7'd0);
            DONE:     issue_ok = 1'b1;
            default:  issue_ok = 1'b0;
        endcase
        read_enb = vld_out & ~hold & issue_ok & ~sreset;
        case (state)
            IDLE:     if (read_enb) state_nxt = HDR_WAIT;
            HDR_WAIT: state_nxt = BODY;
            BODY:     if (last_cap) state_nxt = DONE;
            DONE:     state_nxt = read_enb ? HDR_WAIT : IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (sreset) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= 1'b0;
            issue_rem  <= 7'd0;
            recv_rem   <= 7'd0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            byte_sof   <= 1'b0;
            byte_eof   <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_len    <= 6'd0;
            pkt_addr   <= 2'd0;
            addr_err   <= 1'b0;
            pkt_cnt    <= 8'd0;
        end else begin
            rd_q       <= read_enb;
            byte_valid <= 1'b0;
            byte_sof   <= 1'b0;
            byte_eof   <= 1'b0;
            pkt_done   <= 1'b0;
            if (sreset) begin
                // abort: the byte returning this edge is dropped, summary regs held
                issue_rem <= 7'd0;
                recv_rem  <= 7'd0;
            end else begin
                case (state)
                    HDR_WAIT: begin
                        byte_out   <= d_out;
                        byte_valid <= 1'b1;
                        byte_sof   <= 1'b1;
                        pkt_len    <= d_out[7:2];
                        pkt_addr   <= d_out[1:0];
                        issue_rem  <= {1'b0, d_out[7:2]} + 7'd1;
                        recv_rem   <= {1'b0, d_out[7:2]} + 7'd1;
                    end
                    BODY: begin
                        if (read_enb) issue_rem <= issue_rem - 7'd1;
                        if (rd_q) begin
                            byte_out   <= d_out;
                            byte_valid <= 1'b1;
                            recv_rem   <= recv_rem - 7'd1;
                            if (recv_rem == 7'd1) begin
                                byte_eof <= 1'b1;
                                pkt_done <= 1'b1;
                                addr_err <= (pkt_addr != PORT_ID);
                                pkt_cnt  <= pkt_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        issue_rem <= 7'd0;
                        recv_rem  <= 7'd0;
                    end
                endcase
            end
        end
    end

`ifdef ROUTER_DST_PARITY_CHK_EN
    logic [7:0] acc;

    // acc starts at the header and folds in every payload byte
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= 8'd0;
            parity_err <= 1'b0;
        end else if (sreset) begin
            acc <= 8'd0;
        end else begin
            case (state)
                HDR_WAIT: acc <= d_out;
                BODY: begin
                    if (rd_q) begin
                        if (recv_rem == 7'd1) parity_err <= (acc != d_out);
                        else                  acc        <= acc ^ d_out;
                    end
                end
                default: acc <= 8'd0;
            endcase
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_dst_reader.sv
// Directed bench for router_dst_reader: FIFO model, packet vector table and
// hand-written reset / back-to-back / soft-reset sequences.
module tb_router_dst_reader;

    logic       clk = 1'b0;
    logic       reset, vld_out, sreset, hold;
    logic [7:0] d_out;
    logic       read_enb, byte_valid, byte_sof, byte_eof, pkt_done;
    logic [7:0] byte_out, pkt_cnt;
    logic [5:0] pkt_len;
    logic [1:0] pkt_addr;
    logic       parity_err, addr_err;

    always #5 clk = ~clk;

    router_dst_reader #(.PORT_ID(2'd1)) dut (
        .clk(clk), .reset(reset), .vld_out(vld_out), .d_out(d_out),
        .sreset(sreset), .hold(hold), .read_enb(read_enb),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_sof(byte_sof),
        .byte_eof(byte_eof), .pkt_done(pkt_done), .pkt_len(pkt_len),
        .pkt_addr(pkt_addr), .parity_err(parity_err), .addr_err(addr_err),
        .pkt_cnt(pkt_cnt)
    );

`ifdef ROUTER_DST_PARITY_CHK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    typedef struct {
        logic [7:0][7:0] b;
        int              n;
        int              hold_at, hold_len, starve_at, starve_len;
        logic [5:0]      e_len;
        logic [1:0]      e_addr;
        logic            e_perr, e_aerr;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  fifo[$];
    logic [9:0]  rx_q[$];
    logic [18:0] dn_q[$];
    int          reads, viol, done_issue, n_checks, n_pass;
    logic        starve, tb_rd;
    logic [7:0]  exp_cnt;

    always @(posedge clk) tb_rd <= read_enb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // one clock: drive vld_out, sample pre-edge state, then monitor after the edge
    task automatic cyc();
        logic ch, cv, cr;
        vld_out = (fifo.size() != 0) && !starve;
        #1;
        ch = hold; cv = vld_out; cr = read_enb;
        if (pkt_done && cr) done_issue++;
        @(posedge clk); #1;
        if (tb_rd) begin
            reads++;
            if (ch || !cv) viol++;
            if (fifo.size() != 0) d_out = fifo.pop_front();
        end
        if (byte_valid) rx_q.push_back({byte_sof, byte_eof, byte_out});
        if (pkt_done) dn_q.push_back({byte_valid & byte_eof, pkt_len, pkt_addr, parity_err, addr_err, pkt_cnt});
    endtask

    task automatic clr();
        rx_q.delete(); dn_q.delete();
        reads = 0; viol = 0; done_issue = 0;
    endtask

    function automatic vec_t mk(input logic [63:0] raw, input int n, input int ha, input int hl,
                                input int sa, input int sl, input logic [5:0] ln,
                                input logic [1:0] ad, input logic pe, input logic ae);
        vec_t v;
        v.b = raw; v.n = n;
        v.hold_at = ha; v.hold_len = hl; v.starve_at = sa; v.starve_len = sl;
        v.e_len = ln; v.e_addr = ad; v.e_perr = pe; v.e_aerr = ae;
        return v;
    endfunction

    task automatic run_pkt(input vec_t v, input string nm);
        int c;
        clr();
        for (int i = 0; i < v.n; i++) fifo.push_back(v.b[i]);
        c = 0;
        while (dn_q.size() == 0 && c < 300) begin
            hold   = (c >= v.hold_at) && (c < v.hold_at + v.hold_len);
            starve = (c >= v.starve_at) && (c < v.starve_at + v.starve_len);
            cyc();
            c++;
        end
        hold = 1'b0; starve = 1'b0;
        repeat (3) cyc();
        exp_cnt++;
        chk({nm, " rx_count"}, 32'(rx_q.size()), 32'(v.n));
        for (int i = 0; i < v.n; i++)
            if (i < rx_q.size())
                chk({nm, " byte"}, 32'(rx_q[i]), 32'({i == 0, i == v.n - 1, v.b[i]}));
        chk({nm, " reads"}, 32'(reads), 32'(v.n));
        chk({nm, " gated_reads"}, 32'(viol), 32'd0);
        chk({nm, " done_count"}, 32'(dn_q.size()), 32'd1);
        if (dn_q.size() != 0)
            chk({nm, " summary"}, 32'(dn_q[0]),
                32'({1'b1, v.e_len, v.e_addr, v.e_perr & PCHK, v.e_aerr, exp_cnt}));
    endtask

    initial begin
        logic [7:0] e1, e2;
        int c;
        n_checks = 0; n_pass = 0; exp_cnt = 8'd0;
        reset = 1'b1; sreset = 1'b0; hold = 1'b0; starve = 1'b0;
        d_out = 8'd0; vld_out = 1'b0;
        clr();

        vecs[0] = mk(64'h0000_000D_3322_110D, 5, 0, 0, 0, 0, 6'd3, 2'd1, 1'b0, 1'b0);
        vecs[1] = mk(64'h0000_0000_3322_110C, 5, 0, 0, 0, 0, 6'd3, 2'd0, 1'b1, 1'b1);
        vecs[2] = mk(64'h0000_000D_3322_110D, 5, 2, 4, 8, 3, 6'd3, 2'd1, 1'b0, 1'b0);
        vecs[3] = mk(64'h0000_0000_F5AA_550A, 4, 0, 0, 0, 0, 6'd2, 2'd2, 1'b0, 1'b1);
        vecs[4] = mk(64'h0000_0000_0000_0101, 2, 0, 0, 0, 0, 6'd0, 2'd1, 1'b0, 1'b0);

        cyc(); cyc();
        chk("reset_outputs",
            32'({read_enb, byte_out, byte_valid, byte_sof, byte_eof, pkt_done,
                 pkt_len, pkt_addr, parity_err, addr_err, pkt_cnt}), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_pkt(vecs[i], $sformatf("vec%0d", i));

        // reset mid-stream
        clr();
        for (int i = 0; i < 5; i++) fifo.push_back(vecs[0].b[i]);
        repeat (4) cyc();
        fifo.delete();
        reset = 1'b1;
        cyc(); cyc();
        chk("midreset_outputs",
            32'({read_enb, byte_out, byte_valid, byte_sof, byte_eof, pkt_done,
                 pkt_len, pkt_addr, parity_err, addr_err, pkt_cnt}), 32'd0);
        reset = 1'b0;
        reads = 0;
        repeat (3) cyc();
        chk("midreset_no_reads", 32'(reads), 32'd0);
        chk("midreset_cnt", 32'(pkt_cnt), 32'd0);
        exp_cnt = 8'd0;

        // back-to-back: second header read issues in the DONE cycle
        clr();
        fifo.push_back(8'h04); fifo.push_back(8'hAA); fifo.push_back(8'hAE);
        fifo.push_back(8'h01); fifo.push_back(8'h01);
        c = 0;
        while (dn_q.size() < 2 && c < 300) begin cyc(); c++; end
        repeat (3) cyc();
        e1 = exp_cnt + 8'd1; e2 = exp_cnt + 8'd2; exp_cnt = e2;
        chk("b2b_rx_count", 32'(rx_q.size()), 32'd5);
        chk("b2b_done_count", 32'(dn_q.size()), 32'd2);
        chk("b2b_issue_in_done", 32'(done_issue), 32'd1);
        if (dn_q.size() > 1) begin
            chk("b2b_sum0", 32'(dn_q[0]), 32'({1'b1, 6'd1, 2'd0, 1'b0, 1'b1, e1}));
            chk("b2b_sum1", 32'(dn_q[1]), 32'({1'b1, 6'd0, 2'd1, 1'b0, 1'b0, e2}));
        end
        if (rx_q.size() > 4) begin
            chk("b2b_hdr2", 32'(rx_q[3]), 32'({1'b1, 1'b0, 8'h01}));
            chk("b2b_par2", 32'(rx_q[4]), 32'({1'b0, 1'b1, 8'h01}));
        end

        // soft reset after two payload bytes of a len-5 packet
        clr();
        fifo.push_back(8'h15); fifo.push_back(8'h01); fifo.push_back(8'h02);
        fifo.push_back(8'h03); fifo.push_back(8'h04); fifo.push_back(8'h05);
        fifo.push_back(8'h14);
        c = 0;
        while (rx_q.size() < 3 && c < 300) begin cyc(); c++; end
        fifo.delete();
        sreset = 1'b1;
        cyc();
        chk("sreset_drop_inflight", 32'(byte_valid), 32'd0);
        sreset = 1'b0;
        reads = 0;
        repeat (3) cyc();
        chk("sreset_no_done", 32'(dn_q.size()), 32'd0);
        chk("sreset_held_len_addr", 32'({pkt_len, pkt_addr}), 32'({6'd5, 2'd1}));
        chk("sreset_cnt", 32'(pkt_cnt), 32'(exp_cnt));
        chk("sreset_no_reads", 32'(reads), 32'd0);
        run_pkt(vecs[0], "post_sreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
